// File: rtl/cache_refill_ctrl_pkg.sv
// Shared geometry, FSM encoding and datapath-select struct for the byte-read cache.
package cache_refill_ctrl_pkg;

  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 5;
  localparam int LINE_BYTES = 64;
  localparam int HALF_BYTES = 32;
  localparam int NUM_SETS   = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MEM_REQ = 3'd2,
    S_BEAT0   = 3'd3,
    S_BEAT1   = 3'd4,
    S_RESPOND = 3'd5
  } state_e;

  // Low 9 address bits map directly onto the datapath mux selects.
  typedef struct packed {
    logic [INDEX_W-1:0]  index;
    logic                half;
    logic [OFFSET_W-1:0] offset;
  } dp_sel_t;

endpackage

// File: rtl/cache_refill_ctrl_tag_store.sv
// 8-entry tag + valid array with a combinational hit compare on the selected set.
module cache_tag_store
  import cache_refill_ctrl_pkg::*;
#(
  parameter int TAG_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               wr,
  input  logic               inv,
  input  logic               flush_all,
  output logic               hit
);

  logic             valid [NUM_SETS];
  logic [TAG_W-1:0] tags  [NUM_SETS];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic sel;
    assign sel = (index == INDEX_W'(s));

    always_ff @(posedge clk) begin
      if (!reset || flush_all) valid[s] <= 1'b0;
      else if (sel && wr)      valid[s] <= 1'b1;
      else if (sel && inv)     valid[s] <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset && sel && wr) tags[s] <= tag;
    end
  end

  assign hit = valid[index] && (tags[index] == tag);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill sequencer for the direct-mapped byte-read cache: lookup, two-beat line fetch,
// replayed lookup, and saturating hit/miss statistics.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_valid,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_rvalid,
  output logic [7:0]          cpu_rdata,
  output logic                cpu_hit,
  input  logic                flush,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  output logic [INDEX_W-1:0]  dp_index,
  output logic                dp_half,
  output logic [OFFSET_W-1:0] dp_offset,
  output logic                dp_we,
  output logic                dp_we_half,
  input  logic [7:0]          dp_byte,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int TAG_W = ADDR_W - 9;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic              replay;
  logic              resp_hit;
  logic              tag_hit;
  logic              accept;
  dp_sel_t           req_sel, dp_sel;

  assign req_sel = dp_sel_t'(req_addr[8:0]);
  assign accept  = cpu_valid && cpu_ready;

  cache_tag_store #(.TAG_W(TAG_W)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .index     (req_sel.index),
    .tag       (req_addr[ADDR_W-1:9]),
    .wr        ((state == S_BEAT1) && mem_rvalid),
    .inv       ((state == S_LOOKUP) && !tag_hit),
    .flush_all ((state == S_IDLE) && flush),
    .hit       (tag_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept)     state_nxt = S_LOOKUP;
      S_LOOKUP:  state_nxt = tag_hit ? S_RESPOND : S_MEM_REQ;
      S_MEM_REQ: if (mem_gnt)    state_nxt = S_BEAT0;
      S_BEAT0:   if (mem_rvalid) state_nxt = S_BEAT1;
      S_BEAT1:   if (mem_rvalid) state_nxt = S_LOOKUP;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // cpu_ready is masked by reset so every output reads 0 while reset is held.
  always_comb begin
    cpu_ready  = reset && (state == S_IDLE) && !flush;
    cpu_rvalid = (state == S_RESPOND);
    cpu_hit    = (state == S_RESPOND) && resp_hit;
    mem_req    = (state == S_MEM_REQ);
    mem_addr   = mem_req ? {req_addr[ADDR_W-1:6], 6'b0} : '0;
    dp_sel     = (state == S_IDLE) ? '0 : req_sel;
    dp_we      = ((state == S_BEAT0) || (state == S_BEAT1)) && mem_rvalid;
    dp_we_half = (state == S_BEAT1) && mem_rvalid;
  end

  assign dp_index  = dp_sel.index;
  assign dp_half   = dp_sel.half;
  assign dp_offset = dp_sel.offset;

  // A lookup entered from BEAT1 is a replay: it answers as a miss and is not counted again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_addr  <= '0;
      replay    <= 1'b0;
      resp_hit  <= 1'b0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (accept) begin
        req_addr <= cpu_addr;
        replay   <= 1'b0;
      end
      if ((state == S_BEAT1) && mem_rvalid) replay <= 1'b1;
      if (state == S_LOOKUP) begin
        if (tag_hit) begin
          cpu_rdata <= dp_byte;
          resp_hit  <= !replay;
          if (!replay && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
        end else if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench: behavioural memory + data array, response scoreboard with latency check.
module tb_cache_refill_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready, cpu_rvalid, cpu_hit;
  logic [7:0]        cpu_rdata;
  logic              flush;
  logic              mem_req, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        dp_index;
  logic              dp_half;
  logic [4:0]        dp_offset;
  logic              dp_we, dp_we_half;
  logic [7:0]        dp_byte;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  cache_refill_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .dp_index(dp_index), .dp_half(dp_half), .dp_offset(dp_offset),
    .dp_we(dp_we), .dp_we_half(dp_we_half), .dp_byte(dp_byte),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nresp = 0;

  typedef struct {
    logic [7:0] data;
    logic       hit;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb_q[$];
  logic we_log[$];

  function automatic logic [7:0] bval(input logic [31:0] a);
    logic [7:0] t;
    t = a[16:9];
    return a[7:0] + t * 8'd37;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_to(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timed out", tag);
  endtask

  // Memory model: zero-wait grant, two beats right after the grant edge.
  logic        mem_hold = 1'b0, mem_kill = 1'b0, force_rv = 1'b0;
  int          beats_left = 0;
  logic [31:0] cur_line = '0, last_maddr = '0;
  logic [7:0]  darr [8][2][32];

  always @(negedge clk) begin
    mem_gnt    = mem_req;
    mem_rvalid = ((beats_left > 0) && !mem_hold) || force_rv;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dp_we) begin
      we_log.push_back(dp_we_half);
      for (int i = 0; i < 32; i++)
        darr[dp_index][dp_we_half][i] <= bval(cur_line + 32 * (2 - beats_left) + i);
    end
    if (mem_kill) beats_left <= 0;
    else if (mem_req && mem_gnt) begin
      beats_left <= 2;
      cur_line   <= mem_addr;
      last_maddr <= mem_addr;
    end else if (mem_rvalid && beats_left > 0 && !mem_hold) beats_left <= beats_left - 1;
  end

  assign dp_byte = darr[dp_index][dp_half][dp_offset];

  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rdata", cpu_rdata, e.data);
        chk("cpu_hit", cpu_hit, e.hit);
        chk("latency", cyc - e.acc, e.lat);
      end
      nresp++;
    end
  end

  task automatic do_read(input logic [31:0] a, input logic exp_hit, input int exp_lat);
    int n, r0;
    n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_ready) begin fail_to("ready_wait"); return; end
    cpu_valid = 1'b1;
    cpu_addr  = a;
    sb_q.push_back('{data: bval(a), hit: exp_hit, lat: exp_lat, acc: cyc});
    r0 = nresp;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    n = 0;
    while (nresp == r0 && n < 50) begin @(negedge clk); n++; end
    if (nresp == r0) fail_to("resp_wait");
  endtask

  initial begin
    int n, r0;
    for (int s = 0; s < 8; s++)
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 32; i++) darr[s][h][i] = 8'h00;
    reset = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_dp_we", dp_we, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cpu_ready, 1);

    // Cold miss
    we_log.delete();
    do_read(32'h0000_0140, 1'b0, 6);
    chk("t1_mem_addr", last_maddr, 32'h140);
    chk("t1_we_count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      chk("t1_we_half0", we_log[0], 0);
      chk("t1_we_half1", we_log[1], 1);
    end
    chk("t1_miss_cnt", miss_cnt, 1);
    chk("t1_hit_cnt", hit_cnt, 0);

    // Hit in the upper half
    do_read(32'h0000_0165, 1'b1, 2);
    chk("t2_hit_cnt", hit_cnt, 1);

    // Conflict on index 5
    do_read(32'h0000_0340, 1'b0, 6);
    chk("t3_mem_addr", last_maddr, 32'h340);
    do_read(32'h0000_0140, 1'b0, 6);
    chk("t3_miss_cnt", miss_cnt, 3);
    do_read(32'h0000_015f, 1'b1, 2);

    // Flush wins over a simultaneous request
    @(negedge clk);
    flush = 1'b1; cpu_valid = 1'b1; cpu_addr = 32'h140;
    #1 chk("t4_ready", cpu_ready, 0);
    r0 = nresp;
    @(posedge clk);
    #1 flush = 1'b0; cpu_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_idle", cpu_ready, 1);
    chk("t4_no_resp", nresp, r0);
    do_read(32'h0000_0140, 1'b0, 6);
    chk("t4_miss_cnt", miss_cnt, 4);

    // Reset during BEAT0, then stray beats
    mem_hold = 1'b1;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h340;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    if (!mem_req) fail_to("t5_mem_req");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_kill = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1; mem_kill = 1'b0; mem_hold = 1'b0; force_rv = 1'b1;
    r0 = nresp;
    repeat (2) begin
      @(negedge clk);
      chk("t5_dp_we", dp_we, 0);
    end
    #1 force_rv = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_no_resp", nresp, r0);
    chk("t5_ready", cpu_ready, 1);
    chk("t5_miss_cnt", miss_cnt, 0);
    do_read(32'h0000_0340, 1'b0, 6);
    chk("t5_refetch", miss_cnt, 1);

    // Hit counter saturation
    for (int i = 0; i < 260; i++) begin
      do_read(32'h0000_0340 + (i % 64), 1'b1, 2);
      if (i == 253) chk("t6_hit_254", hit_cnt, 254);
      if (i == 254) chk("t6_hit_255", hit_cnt, 255);
    end
    chk("t6_hit_sat", hit_cnt, 255);
    chk("t6_miss_same", miss_cnt, 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
